add_sub_seq: RTL and testbench

ADD_SUB_SEQ -- requirements
Module: add_sub_seq

---
 rtl/add_sub_pkg.sv | 12 +
 rtl/add_sub_chunk.sv | 36 +++
 rtl/add_sub_seq.sv | 145 ++++++++++++++
 tb/tb_add_sub_seq.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// Shared types and constants for the chunk-serial add/subtract block.
package add_sub_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/add_sub_chunk.sv
// CHUNK-bit ripple-carry adder built from full_adder cells; purely combinational.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module add_sub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);
    logic [CHUNK:0] carry;

    assign carry[0] = ci;
    assign co       = carry[CHUNK];

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (s[i]),
            .co (carry[i+1])
        );
    end
endmodule

// File: rtl/add_sub_seq.sv
// Chunk-serial add/subtract: CHUNK bits per cycle, LSB chunk first, WIDTH/CHUNK cycles.
// Define ADD_SUB_SAT_EN to clamp s to the signed limit on overflow.
//
// state   | meaning
// ST_IDLE | waiting for start; last result held on s/co/ov
// ST_RUN  | one chunk per cycle, cnt_q counts down to the final chunk
module add_sub_seq
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);
    localparam int N  = (CHUNK < 1) ? 1 : WIDTH / CHUNK;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    if (CHUNK < 1) begin : g_bad_chunk
        $error("add_sub_seq: CHUNK must be at least 1");
    end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
        $error("add_sub_seq: WIDTH must be a multiple of CHUNK");
    end

    state_t           state_q, state_d;
    logic             load, last;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q;
    logic             carry_q, a_msb_q, b_msb_q;
    logic [WIDTH-1:0] s_q;
    logic             co_q, ov_q, done_q;

    logic [WIDTH-1:0] b_eff;
    logic [CHUNK-1:0] chunk_s;
    logic             chunk_co;
    logic [WIDTH-1:0] acc_next, s_final, sat_val;
    logic             ov_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        load    = 1'b0;
        last    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    last    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Subtract is folded into the operands at capture: a + ~b + ~ci.
    assign b_eff = (mode == MODE_SUB) ? ~b : b;

    add_sub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a  (a_q[CHUNK-1:0]),
        .b  (b_q[CHUNK-1:0]),
        .ci (carry_q),
        .s  (chunk_s),
        .co (chunk_co)
    );

    // New chunk enters at the top; after N shifts acc holds the full sum in place.
    assign acc_next = WIDTH'({chunk_s, acc_q} >> CHUNK);
    assign ov_next  = (a_msb_q == b_msb_q) && (acc_next[WIDTH-1] != a_msb_q);
    assign sat_val  = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

`ifdef ADD_SUB_SAT_EN
    assign s_final = ov_next ? sat_val : acc_next;
`else
    assign s_final = acc_next;
    logic unused_sat;
    assign unused_sat = ^sat_val;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= last;
            if (load) begin
                a_q     <= a;
                b_q     <= b_eff;
                carry_q <= (mode == MODE_SUB) ? ~ci : ci;
                a_msb_q <= a[WIDTH-1];
                b_msb_q <= b_eff[WIDTH-1];
                acc_q   <= '0;
                cnt_q   <= CNT_LAST;
            end else if (busy) begin
                a_q     <= a_q >> CHUNK;
                b_q     <= b_q >> CHUNK;
                carry_q <= chunk_co;
                acc_q   <= acc_next;
                cnt_q   <= cnt_q - CW'(1);
                if (last) begin
                    s_q  <= s_final;
                    co_q <= chunk_co;
                    ov_q <= ov_next;
                end
            end
        end
    end

    assign done = done_q;
    assign s    = s_q;
    assign co   = co_q;
    assign ov   = ov_q;

endmodule

// File: tb/tb_add_sub_seq.sv
// Directed bench for add_sub_seq (WIDTH=16, CHUNK=4); honours ADD_SUB_SAT_EN.
module tb_add_sub_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        ci = 1'b0;
    logic        busy, done, co, ov;
    logic [15:0] s;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

`ifdef ADD_SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    add_sub_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co),
        .ov    (ov)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic m, input logic [15:0] av,
                          input logic [15:0] bv, input logic c,
                          input logic [15:0] es, input logic eco, input logic eov);
        int cycles, busy_cnt;
        mode = m; a = av; b = bv; ci = c; start = 1'b1;
        step();
        start = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; mode = ~m; ci = ~c;
        cycles = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && cycles < 10) begin
            if (busy === 1'b1) busy_cnt++;
            step();
            cycles++;
        end
        chk({tag, "_latency"}, 32'(cycles), 32'd4);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
        chk({tag, "_s"}, 32'(s), 32'(es));
        chk({tag, "_co"}, 32'(co), 32'(eco));
        chk({tag, "_ov"}, 32'(ov), 32'(eov));
        step();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_s_held"}, 32'(s), 32'(es));
    endtask

    initial begin
        int dc;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_co", 32'(co), 32'd0);
        chk("rst_ov", 32'(ov), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        run_op("add1", 1'b0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
        run_op("sub1", 1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_ov", 1'b1, 16'h8000, 16'h0001, 1'b0,
               SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1);
        run_op("add_ov", 1'b0, 16'h7FFF, 16'h0001, 1'b0,
               SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1);
        run_op("add_wrap", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_ci", 1'b0, 16'h00FF, 16'h0F00, 1'b1, 16'h1000, 1'b0, 1'b0);
        run_op("sub_ci", 1'b1, 16'h0010, 16'h0001, 1'b1, 16'h000E, 1'b1, 1'b0);

        // start while busy is ignored; start in the done cycle is accepted
        dc = done_cnt;
        mode = 1'b0; a = 16'h0001; b = 16'h0001; ci = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        mode = 1'b1; a = 16'hFFFF; b = 16'h1234; ci = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_start_busy", 32'(busy), 32'd1);
        chk("busy_start_nodone", 32'(done), 32'd0);
        step();
        chk("busy_start_done", 32'(done), 32'd1);
        chk("busy_start_s", 32'(s), 32'h0002);
        chk("busy_start_co", 32'(co), 32'd0);
        mode = 1'b0; a = 16'h0100; b = 16'h0023; ci = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk("done_start_busy", 32'(busy), 32'd1);
        chk("done_start_held", 32'(s), 32'h0002);
        chk("single_done", 32'(done_cnt - dc), 32'd1);
        step();
        step();
        step();
        chk("done_start_nodone", 32'(done), 32'd0);
        chk("done_start_held2", 32'(s), 32'h0002);
        step();
        chk("done_start_done", 32'(done), 32'd1);
        chk("done_start_s", 32'(s), 32'h0123);
        step();

        // reset in the middle of an operation
        dc = done_cnt;
        mode = 1'b0; a = 16'h1111; b = 16'h2222; ci = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_s", 32'(s), 32'd0);
        chk("abort_co", 32'(co), 32'd0);
        chk("abort_ov", 32'(ov), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        step();
        chk("abort_no_done", 32'(done_cnt - dc), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);
        run_op("post_rst", 1'b0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
